// File: rtl/shift_out_serializer.sv
// ---------------------------------------------------------------------------
// shift_out_serializer
//
// Takes each parallel word from the barrel shifter through a valid/ready
// handshake. It then sends the word out as a framed serial bitstream, one bit
// per clock. Back-to-back frames run with no gap: a new word can be taken on
// the last bit cycle of the frame in progress.
//
// Optional build macro:
//   SER_PARITY_EN - adds one even-parity bit after the last data bit, so a
//                   frame is DATA_W+1 bits long. Parity is the XOR of the
//                   accepted word, computed when the word is accepted.
//
// Parameters:
//   DATA_W    width of the parallel word (must be >= 2)
//   LSB_FIRST 0: din[DATA_W-1] goes out first, 1: din[0] goes out first
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   din         parallel word from the barrel shifter
//   din_valid   din holds a word this cycle
//   din_ready   a word can be accepted this cycle (combinational)
//   sout        serial data bit
//   sout_valid  sout carries a frame bit
//   frame_start high on the first bit cycle of a frame
//   frame_done  high on the last bit cycle of a frame
//   busy        high while a frame is being sent
//
// States:
//   state | meaning
//   IDLE  | no frame in flight, waiting for a word
//   SHIFT | sending a frame; cnt_q counts the bits still to go after this one
// ---------------------------------------------------------------------------
module shift_out_serializer #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef SER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic accept;
  logic last_bit;

  assign last_bit  = (state_q == SHIFT) && (cnt_q == '0);
  assign din_ready = !rst && ((state_q == IDLE) || last_bit);
  assign accept    = din_valid && din_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef SER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SHIFT;
          shreg_d  = din;
          cnt_d    = CNT_LAST;
`ifdef SER_PARITY_EN
          parity_d = ^din;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          // Last bit: reload here for a gapless next frame, otherwise go idle.
          if (accept) begin
            shreg_d  = din;
            cnt_d    = CNT_LAST;
`ifdef SER_PARITY_EN
            parity_d = ^din;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (LSB_FIRST != 0) shreg_d = shreg_q >> 1;
          else                shreg_d = shreg_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    busy        = 1'b0;
    if (state_q == SHIFT) begin
      sout_valid  = 1'b1;
      busy        = 1'b1;
      frame_start = (cnt_q == CNT_LAST);
      frame_done  = (cnt_q == '0);
      if (LSB_FIRST != 0) sout = shreg_q[0];
      else                sout = shreg_q[DATA_W-1];
`ifdef SER_PARITY_EN
      // With parity on, the data bits have all been sent by count 0.
      if (cnt_q == '0) sout = parity_q;
`endif
    end
  end

endmodule

// File: tb/tb_shift_out_serializer.sv
module tb_shift_out_serializer;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;

  logic rdy0, so0, sv0, fs0, fd0, bz0;
  logic rdy1, so1, sv1, fs1, fd1, bz1;

  int tests = 0;
  int fails = 0;

  shift_out_serializer #(.DATA_W(8), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy0),
    .sout(so0), .sout_valid(sv0), .frame_start(fs0), .frame_done(fd0), .busy(bz0));

  shift_out_serializer #(.DATA_W(8), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy1),
    .sout(so1), .sout_valid(sv1), .frame_start(fs1), .frame_done(fd1), .busy(bz1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the word in flight and how many of its bits remain to be sent.
  logic [7:0] m_word = 8'h00;
  int         m_rem  = 0;
  bit         chk_en = 1'b0;

  function automatic logic exp_bit(input logic [7:0] w, input int p, input bit lsb);
    if (p >= 8) return ^w;
    return lsb ? w[p] : w[7-p];
  endfunction

  always @(posedge clk) begin
    if (rst) m_rem = 0;
    else if (din_valid && (m_rem <= 1)) begin
      m_word = din;
      m_rem  = FL;
    end else if (m_rem > 0) m_rem = m_rem - 1;
  end

  // Serial streams captured for the literal checks (first bit ends up highest).
  logic [31:0] cap0 = 0, cap1 = 0;
  int          n0 = 0, n1 = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int  p;
      bit  act;
      logic mrdy;
      p    = FL - m_rem;
      act  = (m_rem > 0);
      mrdy = !rst && (m_rem <= 1);
      chk("valid0", 32'(sv0), 32'(act));
      chk("busy0",  32'(bz0), 32'(act));
      chk("start0", 32'(fs0), 32'(m_rem == FL));
      chk("done0",  32'(fd0), 32'(m_rem == 1));
      chk("ready0", 32'(rdy0), 32'(mrdy));
      chk("sout0",  32'(so0), act ? 32'(exp_bit(m_word, p, 1'b0)) : 32'd0);
      chk("valid1", 32'(sv1), 32'(act));
      chk("start1", 32'(fs1), 32'(m_rem == FL));
      chk("done1",  32'(fd1), 32'(m_rem == 1));
      chk("ready1", 32'(rdy1), 32'(mrdy));
      chk("sout1",  32'(so1), act ? 32'(exp_bit(m_word, p, 1'b1)) : 32'd0);
    end
    if (sv0) begin cap0 = {cap0[30:0], so0}; n0++; end
    if (sv1) begin cap1 = {cap1[30:0], so1}; n1++; end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cap();
    cap0 = 0; cap1 = 0; n0 = 0; n1 = 0;
  endtask

  // Offer a word and hold it until taken; returns the cycles spent waiting.
  task automatic send(input logic [7:0] w, output int waits);
    din = w;
    din_valid = 1'b1;
    waits = 0;
    while (!rdy0 && waits < 40) begin
      tick();
      waits++;
    end
    if (waits >= 40) chk("ready_timeout", 32'(waits), 32'd0);
    tick();
    din_valid = 1'b0;
    din = 8'h5A;
  endtask

  task automatic drain();
    repeat (FL + 3) tick();
  endtask

  initial begin
    int w;
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_valid", 32'(sv0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(rdy0), 32'd1);
    chk("idle_busy",  32'(bz0), 32'd0);

    // Single frame 0x80
    clear_cap();
    send(8'h80, w);
    drain();
`ifdef SER_PARITY_EN
    chk("f80_msb", cap0, 32'h101);
    chk("f80_lsb", cap1, 32'h003);
`else
    chk("f80_msb", cap0, 32'h80);
    chk("f80_lsb", cap1, 32'h01);
`endif
    chk("f80_len", 32'(n0), 32'(FL));
    chk("f80_ready_after", 32'(rdy0), 32'd1);

    // Back-to-back 0xF0, 0x0F
    clear_cap();
    send(8'hF0, w);
    send(8'h0F, w);
    drain();
`ifdef SER_PARITY_EN
    chk("b2b_msb", cap0, 32'h3C01E);
    chk("b2b_lsb", cap1, 32'h03DE0);
`else
    chk("b2b_msb", cap0, 32'hF00F);
    chk("b2b_lsb", cap1, 32'h0FF0);
`endif
    chk("b2b_len", 32'(n0), 32'(2 * FL));

    // Hold-off: 0xAA offered from bit cycle 2 is taken only on the last bit
    clear_cap();
    send(8'h3C, w);
    tick();
    send(8'hAA, w);
    chk("hold_waits", 32'(w), 32'(FL - 2));
    drain();
`ifndef SER_PARITY_EN
    chk("hold_msb", cap0, 32'h3CAA);
    chk("hold_lsb", cap1, 32'h3C55);
`endif

    // Reset during bit 4 of 0xFF
    send(8'hFF, w);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(sv0), 32'd0);
    chk("rst_mid_busy",  32'(bz0), 32'd0);
    chk("rst_mid_sout",  32'(so0), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(rdy0), 32'd1);
    clear_cap();
    send(8'h01, w);
    drain();
`ifdef SER_PARITY_EN
    chk("f01_msb", cap0, 32'h003);
    chk("f01_lsb", cap1, 32'h101);
`else
    chk("f01_msb", cap0, 32'h01);
    chk("f01_lsb", cap1, 32'h80);
`endif

    // 0x07 and 0x03 (parity 1 and 0 when parity is built in)
    clear_cap();
    send(8'h07, w);
    drain();
`ifdef SER_PARITY_EN
    chk("f07_msb", cap0, 32'h00F);
    chk("f07_lsb", cap1, 32'h1C1);
`else
    chk("f07_msb", cap0, 32'h07);
    chk("f07_lsb", cap1, 32'hE0);
`endif
    clear_cap();
    send(8'h03, w);
    drain();
`ifdef SER_PARITY_EN
    chk("f03_msb", cap0, 32'h006);
    chk("f03_lsb", cap1, 32'h180);
`else
    chk("f03_msb", cap0, 32'h03);
    chk("f03_lsb", cap1, 32'hC0);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_out_serializer.md
Name: shift_out_serializer

Overview:
- Downstream stage of the 8-bit barrel shifter. Captures each shifted parallel word with a valid/ready handshake and emits it as a framed serial bitstream, one bit per clock.
- Adds the buffering and sequencing the combinational shifter lacks, so shifted results can drive a serial link or pin.
- Supports gapless back-to-back frames.

Parameters:
- DATA_W, 8: width of the parallel input word; must be >= 2.
- LSB_FIRST, 0: bit order. 0 sends din[DATA_W-1] first; 1 sends din[0] first.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DATA_W  parallel word from the barrel shifter output.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  serializer can accept din this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  pulses on the first bit cycle of a frame.
- frame_done  output  1  pulses on the last bit cycle of a frame.
- busy  output  1  high while a frame is being emitted.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset values: sout=0, sout_valid=0, frame_start=0, frame_done=0, busy=0, shift register=0, bit counter=0, state=IDLE.
- din_ready is combinational: 0 while rst=1; otherwise 1 in IDLE or on the last bit cycle of a frame, and 0 elsewhere.
- Accept: a word is taken on a rising edge when din_valid && din_ready. din is ignored when din_ready=0, and no word is lost or duplicated.
- Latency: the first frame bit appears on sout (with sout_valid=1) in the cycle immediately after acceptance.
- States:
  - IDLE: sout_valid=0, busy=0, sout=0. On accept, load the shift register, set the counter to FRAME_LEN-1, and go to SHIFT.
  - SHIFT: one bit per cycle; sout_valid=1, busy=1. The counter decrements each cycle.
  - At count 0 (last bit cycle), frame_done=1. If an accept occurs on that edge, reload and remain in SHIFT with no idle gap (the next frame_start follows frame_done on the very next cycle). Otherwise return to IDLE.
- FRAME_LEN = DATA_W, or DATA_W+1 with the optional feature.
- frame_start is 1 only in the first bit cycle of each frame. For a 1-bit-per-cycle frame of length FRAME_LEN >= 2, frame_start and frame_done are never high together.
- Bit order: MSB-first shifts left, taking the MSB each cycle; LSB-first shifts right, taking the LSB each cycle. Vacated bits fill with 0.
- Reset mid-frame: the frame is aborted with no partial completion. All outputs return to reset values on the next edge, and the word in flight is discarded.
- din may change freely after acceptance; the serializer uses only its internal copy.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: FRAME_LEN=DATA_W+1. The parity bit is the XOR of all DATA_W bits of the accepted word (even parity) and is computed at accept time. It is appended after the last data bit, and frame_done is asserted on the parity cycle; din_ready is asserted there for back-to-back frames.
- Undefined: FRAME_LEN=DATA_W, there is no parity logic, and frame_done falls on the last data bit.

Test Plan:
- Reset, then din=8'h80, din_valid=1 for one cycle, LSB_FIRST=0 -> starting the next cycle, sout=1,0,0,0,0,0,0,0 over 8 cycles with sout_valid=1; frame_start on cycle 1; frame_done on cycle 8; then IDLE, din_ready=1.
- Back-to-back: din=8'hF0 accepted, din_valid held with din=8'h0F -> 8'h0F accepted on the frame_done cycle of the first frame; 16 contiguous valid bits 1111000000001111 with no gap.
- Hold-off: din_valid=1 with din=8'hAA during mid-frame cycles 2-6 -> din_ready=0, current frame unchanged; 8'hAA is accepted only on the last bit cycle.
- Reset mid-frame: rst=1 during bit 4 of 8'hFF -> next cycle sout_valid=0, busy=0, sout=0; after rst drops, din_ready=1 and a fresh 8'h01 frame is emitted correctly.
- LSB_FIRST=1, din=8'h01 -> sout=1,0,0,0,0,0,0,0; din=8'h80 -> sout=0,0,0,0,0,0,0,1.
- With SER_PARITY_EN, din=8'h07 -> 9 valid bits, 00000111 then parity 1, frame_done on bit 9. With din=8'h03 -> parity 0.
